mac_cipher_out_serializer: RTL and testbench

- Output stage of the AES/SHA3 Top datapath. It sits directly downstream of the AES core and the HMAC-SHA3 core.
- Accepts one 128-bit cipher block and one 256-bit HMAC value per message. Streams them onto the byte-serial o_data/o_valid port: the 16 cipher bytes first, then the 32 MAC bytes.
- o_valid drops between the two bursts, so a consumer can frame each burst on the rising edge of o_valid.

---
 rtl/aes_sha3_pkg.sv | 15 +
 rtl/byte_shifter.sv | 36 +++
 rtl/mac_cipher_out_serializer.sv | 143 ++++++++++++++
 tb/tb_mac_cipher_out_serializer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sha3_pkg.sv
// Shared constants and types for the AES/SHA3 top datapath output stage.
package aes_sha3_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int MAC_BYTES   = 32;

  typedef enum logic [2:0] {
    IDLE,
    CIPH,
    GAP,
    MWAIT,
    MAC
  } out_state_t;

endpackage

// File: rtl/byte_shifter.sv
// Load / shift-right-by-8 register with a byte counter; last_o marks the final byte of a burst.
module byte_shifter #(
  parameter int BYTES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [BYTES*8-1:0] data_i,
  input  logic               shift_i,
  output logic [7:0]         byte_o,
  output logic               last_o
);

  localparam int CW = $clog2(BYTES);

  logic [BYTES*8-1:0] sh_q;
  logic [CW-1:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sh_q <= sh_q >> 8;
      // Hold on the final byte so the counter never wraps inside a burst.
      if (!last_o) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign byte_o = sh_q[7:0];
  assign last_o = (cnt_q == CW'(BYTES - 1));

endmodule

// File: rtl/mac_cipher_out_serializer.sv
// Streams one cipher block then one buffered HMAC value onto a byte-serial port,
// with a fixed idle gap between the two bursts and a done pulse after the last MAC byte.
//
// state | meaning
// IDLE  | ready for a new cipher block
// CIPH  | streaming cipher bytes
// GAP   | fixed idle cycles between bursts
// MWAIT | cipher done, waiting for the MAC to arrive
// MAC   | streaming MAC bytes
module mac_cipher_out_serializer #(
  parameter int CIPHER_BYTES = aes_sha3_pkg::BLOCK_BYTES,
  parameter int MAC_BYTES    = aes_sha3_pkg::MAC_BYTES,
  parameter int GAP_CYC      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CIPHER_BYTES*8-1:0] i_cipher,
  input  logic                    i_cipher_valid,
  output logic                    o_cipher_ready,
  input  logic [MAC_BYTES*8-1:0]  i_mac,
  input  logic                    i_mac_valid,
  output logic                    o_mac_ready,
  output logic [7:0]              o_data,
  output logic                    o_valid,
  output logic                    o_busy,
  output logic                    o_done
);

  import aes_sha3_pkg::*;

  out_state_t state_q;
  logic [3:0] gap_q;
  logic       mac_full_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;
  logic       cready_q;

  logic       cipher_xfer;
  logic       mac_xfer;
  logic [7:0] c_byte;
  logic [7:0] m_byte;
  logic       c_last;
  logic       m_last;

  assign cipher_xfer = i_cipher_valid && cready_q;
  // busy_q is exactly "state != IDLE", so the MAC is never taken while idle.
  assign mac_xfer    = i_mac_valid && busy_q && !mac_full_q;

  byte_shifter #(.BYTES(CIPHER_BYTES)) u_cipher_sh (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cipher_xfer),
    .data_i  (i_cipher),
    .shift_i (state_q == CIPH),
    .byte_o  (c_byte),
    .last_o  (c_last)
  );

  byte_shifter #(.BYTES(MAC_BYTES)) u_mac_sh (
    .clk     (clk),
    .rst     (rst),
    .load_i  (mac_xfer),
    .data_i  (i_mac),
    .shift_i (state_q == MAC),
    .byte_o  (m_byte),
    .last_o  (m_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      mac_full_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (mac_xfer) mac_full_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (i_cipher_valid) begin
            state_q  <= CIPH;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            cready_q <= 1'b0;
          end
        end
        CIPH: begin
          if (c_last) begin
            state_q <= GAP;
            valid_q <= 1'b0;
            gap_q   <= 4'(GAP_CYC - 1);
          end
        end
        GAP: begin
          if (gap_q == 4'd0) begin
            if (mac_full_q) begin
              state_q <= MAC;
              valid_q <= 1'b1;
            end else begin
              state_q <= MWAIT;
            end
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        MWAIT: begin
          if (mac_full_q) begin
            state_q <= MAC;
            valid_q <= 1'b1;
          end
        end
        MAC: begin
          if (m_last) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cready_q   <= 1'b1;
            mac_full_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          cready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_cipher_ready = cready_q;
  assign o_mac_ready    = busy_q && !mac_full_q;
  assign o_valid        = valid_q;
  assign o_data         = !valid_q ? 8'h00 : (state_q == MAC) ? m_byte : c_byte;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_mac_cipher_out_serializer.sv
// Randomized scoreboard bench for the cipher/MAC output serializer.
module tb_mac_cipher_out_serializer;

  localparam int CB  = 16;
  localparam int MB  = 32;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CB*8-1:0] i_cipher = '0;
  logic           i_cipher_valid = 1'b0;
  logic           o_cipher_ready;
  logic [MB*8-1:0] i_mac = '0;
  logic           i_mac_valid = 1'b0;
  logic           o_mac_ready;
  logic [7:0]     o_data;
  logic           o_valid;
  logic           o_busy;
  logic           o_done;

  mac_cipher_out_serializer #(
    .CIPHER_BYTES (CB),
    .MAC_BYTES    (MB),
    .GAP_CYC      (GAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cipher       (i_cipher),
    .i_cipher_valid (i_cipher_valid),
    .o_cipher_ready (o_cipher_ready),
    .i_mac          (i_mac),
    .i_mac_valid    (i_mac_valid),
    .o_mac_ready    (o_mac_ready),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cy;
    logic [7:0] b;
  } exp_t;

  exp_t bq[$];
  int   dq[$];

  int errors = 0;
  int checks = 0;

  // Reference model of the message in flight, kept as edge numbers.
  int t_c = 0, m_e = 0, done_e = 0, mstart = 0;
  bit have_c = 0, have_m = 0;
  bit chk_en = 0;
  int n_done = 0, n_rise = 0, n_msgs = 0;
  bit prev_v = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endfunction

  always @(negedge clk) begin
    bit         v_exp;
    bit         d_exp;
    bit         busy_e;
    bit         mfull_e;
    logic [7:0] b_exp;
    if (chk_en) begin
      while (bq.size() > 0 && bq[0].cy < cyc) begin
        chk("byte_time", 64'(cyc), 64'(bq[0].cy));
        void'(bq.pop_front());
      end
      v_exp = (bq.size() > 0 && bq[0].cy == cyc);
      b_exp = v_exp ? bq[0].b : 8'h00;
      chk("o_valid", 64'(o_valid), 64'(v_exp));
      chk("o_data", 64'(o_data), 64'(b_exp));
      if (v_exp) void'(bq.pop_front());

      while (dq.size() > 0 && dq[0] < cyc) begin
        chk("done_time", 64'(cyc), 64'(dq[0]));
        void'(dq.pop_front());
      end
      d_exp = (dq.size() > 0 && dq[0] == cyc);
      chk("o_done", 64'(o_done), 64'(d_exp));
      if (d_exp) void'(dq.pop_front());

      if (o_done === 1'b1) n_done++;
      if (o_valid === 1'b1 && !prev_v) n_rise++;
      prev_v = (o_valid === 1'b1);

      busy_e  = have_c && cyc >= t_c && (!have_m || cyc < done_e);
      mfull_e = have_m && cyc >= m_e && cyc < done_e;
      chk("o_busy", 64'(o_busy), 64'(busy_e));
      chk("o_cipher_ready", 64'(o_cipher_ready), 64'(!busy_e));
      chk("o_mac_ready", 64'(o_mac_ready), 64'(busy_e && !mfull_e));

      if (rst) begin
        bq.delete();
        dq.delete();
        have_c = 0;
        have_m = 0;
      end else begin
        if (i_cipher_valid && o_cipher_ready) begin
          t_c    = cyc + 1;
          have_c = 1;
          have_m = 0;
          for (int i = 0; i < CB; i++) bq.push_back('{t_c + i, i_cipher[8*i +: 8]});
        end
        if (i_mac_valid && o_mac_ready && have_c) begin
          m_e    = cyc + 1;
          have_m = 1;
          // MAC burst starts after cipher + gap, or one cycle after the MAC lands.
          mstart = (t_c + CB + GAP > m_e + 1) ? (t_c + CB + GAP) : (m_e + 1);
          for (int j = 0; j < MB; j++) bq.push_back('{mstart + j, i_mac[8*j +: 8]});
          done_e = mstart + MB;
          dq.push_back(done_e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cipher(input logic [CB*8-1:0] d);
    int n = 0;
    i_cipher       = d;
    i_cipher_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (o_cipher_ready !== 1'b1 && n < 500);
    if (o_cipher_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL cipher_handshake_timeout: got no ready after %0d cycles, required ready", n);
    end
    @(posedge clk);
    #1;
    i_cipher_valid = 1'b0;
  endtask

  task automatic send_mac(input logic [MB*8-1:0] d);
    int n = 0;
    i_mac       = d;
    i_mac_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (o_mac_ready !== 1'b1 && n < 500);
    if (o_mac_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL mac_handshake_timeout: got no ready after %0d cycles, required ready", n);
    end
    @(posedge clk);
    #1;
    i_mac_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() > 0 || dq.size() > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    checks++;
    if (bq.size() > 0 || dq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes and %0d dones pending, required 0", bq.size(), dq.size());
    end
  endtask

  function automatic logic [CB*8-1:0] rnd_cipher();
    logic [CB*8-1:0] v;
    for (int i = 0; i < CB / 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [MB*8-1:0] rnd_mac();
    logic [MB*8-1:0] v;
    for (int i = 0; i < MB / 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [CB*8-1:0] c;
    logic [MB*8-1:0] m;
    int d0, r0;

    idle(3);
    chk_en = 1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // Basic: incrementing patterns offered together while idle.
    for (int i = 0; i < CB; i++) c[8*i +: 8] = 8'(i);
    for (int j = 0; j < MB; j++) m[8*j +: 8] = 8'(j);
    fork
      send_cipher(c);
      send_mac(m);
    join
    n_msgs++;
    drain();

    // Late MAC: long MWAIT hold.
    c = rnd_cipher();
    m = rnd_mac();
    send_cipher(c);
    idle(CB + GAP + 20);
    send_mac(m);
    n_msgs++;
    drain();

    // Back-pressure: a second MAC waits while the first is buffered.
    fork
      send_cipher(rnd_cipher());
      send_mac(rnd_mac());
    join
    fork
      send_mac(rnd_mac());
      begin
        idle(70);
        send_cipher(rnd_cipher());
      end
    join
    n_msgs += 2;
    drain();

    // Reset in the middle of the cipher burst, during byte 7.
    send_cipher(rnd_cipher());
    idle(7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    fork
      send_cipher(rnd_cipher());
      send_mac(rnd_mac());
    join
    n_msgs++;
    drain();

    // Back-to-back messages.
    d0 = n_done;
    r0 = n_rise;
    fork
      for (int k = 0; k < 5; k++) send_cipher(rnd_cipher());
      for (int k = 0; k < 5; k++) send_mac(rnd_mac());
    join
    n_msgs += 5;
    drain();
    chk("b2b_done_pulses", 64'(n_done - d0), 64'(5));
    chk("b2b_burst_starts", 64'(n_rise - r0), 64'(10));

    // Random data and random MAC arrival times.
    for (int k = 0; k < 15; k++) begin
      int dly;
      dly = $urandom_range(0, 40);
      c = rnd_cipher();
      m = rnd_mac();
      fork
        send_cipher(c);
        begin
          idle(dly);
          send_mac(m);
        end
      join
      n_msgs++;
      idle($urandom_range(0, 5));
    end
    drain();

    chk("total_done_pulses", 64'(n_done), 64'(n_msgs));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
